// File: rtl/mem_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_scan_ctrl                                                              |
// | Walks an inclusive address range with single-beat reads and forwards each  |
// | returned word on a valid/ready stream; supports gap, abort, stop-on-error. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_scan_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int GAP_CYCLES = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] cfg_begin_i,
  input  logic [ADDR_W-1:0] cfg_end_i,
  input  logic [1:0]        cfg_size_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic [ADDR_W-1:0] beat_count_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [1:0]        mem_size_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_rerr_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              out_last_o,
  input  logic              out_ready_i
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GAP  = 3'd1,
    S_REQ  = 3'd2,
    S_WAIT = 3'd3,
    S_PUSH = 3'd4
  } state_t;

  localparam int                 c_GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [c_GAP_W-1:0] c_GAP_LAST   = c_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam state_t             c_BEAT_START = (GAP_CYCLES == 0) ? S_REQ : S_GAP;

  function automatic logic [ADDR_W-1:0] f_stride(input logic [1:0] size);
    case (size)
      2'd0:    return ADDR_W'(2);
      2'd1:    return ADDR_W'(4);
      default: return ADDR_W'(8);
    endcase
  endfunction

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_end;
  logic [1:0]          r_size;
  logic [c_GAP_W-1:0]  r_gap_cnt;
  logic                r_abort_pend;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic [ADDR_W-1:0]   r_err_addr;
  logic [ADDR_W-1:0]   r_beat_count;
  logic                r_mem_req;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic [ADDR_W-1:0]   r_out_addr;
  logic                r_out_last;

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [ADDR_W-1:0]   w_end_nxt;
  logic [1:0]          w_size_nxt;
  logic [c_GAP_W-1:0]  w_gap_cnt_nxt;
  logic                w_abort_nxt;
  logic                w_done_nxt;
  logic                w_error_nxt;
  logic [ADDR_W-1:0]   w_err_addr_nxt;
  logic [ADDR_W-1:0]   w_beat_nxt;
  logic                w_out_valid_nxt;
  logic [DATA_W-1:0]   w_out_data_nxt;
  logic [ADDR_W-1:0]   w_out_addr_nxt;
  logic                w_out_last_nxt;

  logic [ADDR_W-1:0]   w_cfg_stride;
  logic [ADDR_W-1:0]   w_cfg_mask;
  logic                w_cfg_bad;
  logic                w_at_end;

  // Alignment of both begin and span is required so that the end address is
  // hit exactly by repeated stride increments and never wrapped past.
  assign w_cfg_stride = f_stride(cfg_size_i);
  assign w_cfg_mask   = w_cfg_stride - ADDR_W'(1);
  assign w_cfg_bad    = (cfg_size_i == 2'd3)
                      || (cfg_end_i < cfg_begin_i)
                      || ((cfg_begin_i & w_cfg_mask) != '0)
                      || (((cfg_end_i - cfg_begin_i) & w_cfg_mask) != '0);
  assign w_at_end     = (r_addr == r_end);

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_end_nxt       = r_end;
    w_size_nxt      = r_size;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_abort_nxt     = r_abort_pend;
    w_done_nxt      = 1'b0;
    w_error_nxt     = r_error;
    w_err_addr_nxt  = r_err_addr;
    w_beat_nxt      = r_beat_count;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_addr_nxt  = r_out_addr;
    w_out_last_nxt  = r_out_last;

    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_end_nxt     = cfg_end_i;
          w_size_nxt    = cfg_size_i;
          w_addr_nxt    = cfg_begin_i;
          w_beat_nxt    = '0;
          w_gap_cnt_nxt = '0;
          w_abort_nxt   = 1'b0;
          if (w_cfg_bad) begin
            w_error_nxt    = 1'b1;
            w_err_addr_nxt = cfg_begin_i;
            w_done_nxt     = 1'b1;
          end else begin
            w_error_nxt = 1'b0;
            w_state_nxt = c_BEAT_START;
          end
        end
      end

      S_GAP: begin
        if (abort_i) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_gap_cnt == c_GAP_LAST) begin
          w_gap_cnt_nxt = '0;
          w_state_nxt   = S_REQ;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + c_GAP_W'(1);
        end
      end

      S_REQ: begin
        // A grant beats a simultaneous abort; the abort is then honoured once
        // the response has drained.
        if (mem_gnt_i) begin
          w_abort_nxt = abort_i;
          w_state_nxt = S_WAIT;
        end else if (abort_i) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      S_WAIT: begin
        if (mem_rvalid_i) begin
          w_abort_nxt = 1'b0;
          if (r_abort_pend || abort_i) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (mem_rerr_i) begin
            w_error_nxt    = 1'b1;
            w_err_addr_nxt = r_addr;
            w_done_nxt     = 1'b1;
            w_state_nxt    = S_IDLE;
          end else begin
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = mem_rdata_i;
            w_out_addr_nxt  = r_addr;
            w_out_last_nxt  = w_at_end;
            w_state_nxt     = S_PUSH;
          end
        end else if (abort_i) begin
          w_abort_nxt = 1'b1;
        end
      end

      S_PUSH: begin
        if (out_ready_i) begin
          w_out_valid_nxt = 1'b0;
          w_out_last_nxt  = 1'b0;
          w_beat_nxt      = r_beat_count + ADDR_W'(1);
          if (w_at_end) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_addr_nxt    = r_addr + f_stride(r_size);
            w_gap_cnt_nxt = '0;
            w_state_nxt   = c_BEAT_START;
          end
        end else if (abort_i) begin
          w_out_valid_nxt = 1'b0;
          w_out_last_nxt  = 1'b0;
          w_done_nxt      = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_end        <= '0;
      r_size       <= '0;
      r_gap_cnt    <= '0;
      r_abort_pend <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_err_addr   <= '0;
      r_beat_count <= '0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_addr   <= '0;
      r_out_last   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_end        <= w_end_nxt;
      r_size       <= w_size_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
      r_abort_pend <= w_abort_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= w_done_nxt;
      r_error      <= w_error_nxt;
      r_err_addr   <= w_err_addr_nxt;
      r_beat_count <= w_beat_nxt;
      r_mem_req    <= (w_state_nxt == S_REQ);
      r_mem_addr   <= w_addr_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_data   <= w_out_data_nxt;
      r_out_addr   <= w_out_addr_nxt;
      r_out_last   <= w_out_last_nxt;
    end
  end

  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign error_o      = r_error;
  assign err_addr_o   = r_err_addr;
  assign beat_count_o = r_beat_count;
  assign mem_req_o    = r_mem_req;
  assign mem_addr_o   = r_mem_addr;
  assign mem_size_o   = r_size;
  assign out_valid_o  = r_out_valid;
  assign out_data_o   = r_out_data;
  assign out_addr_o   = r_out_addr;
  assign out_last_o   = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_mem_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_scan_ctrl                                                           |
// | Self-checking bench: vector table, directed corner cases, random scans.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_scan_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i = 1'b1, start_i = 1'b0, abort_i = 1'b0;
  logic [AW-1:0] cfg_begin_i = '0, cfg_end_i = '0;
  logic [1:0]    cfg_size_i = '0;
  logic          mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, mem_rerr_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          out_ready_i = 1'b1;

  logic [1:0]    d_busy, d_done, d_error, d_mem_req, d_out_valid, d_out_last;
  logic [AW-1:0] d_err_addr [2];
  logic [AW-1:0] d_beat [2];
  logic [AW-1:0] d_mem_addr [2];
  logic [AW-1:0] d_out_addr [2];
  logic [1:0]    d_mem_size [2];
  logic [DW-1:0] d_out_data [2];

  // Instance 0 uses an 8-cycle gap, instance 1 has no gap.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_scan_ctrl #(.ADDR_W(AW), .DATA_W(DW), .GAP_CYCLES(g == 0 ? 8 : 0)) u_dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
      .cfg_begin_i(cfg_begin_i), .cfg_end_i(cfg_end_i), .cfg_size_i(cfg_size_i),
      .busy_o(d_busy[g]), .done_o(d_done[g]), .error_o(d_error[g]),
      .err_addr_o(d_err_addr[g]), .beat_count_o(d_beat[g]),
      .mem_req_o(d_mem_req[g]), .mem_addr_o(d_mem_addr[g]), .mem_size_o(d_mem_size[g]),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .mem_rerr_i(mem_rerr_i), .out_valid_o(d_out_valid[g]), .out_data_o(d_out_data[g]),
      .out_addr_o(d_out_addr[g]), .out_last_o(d_out_last[g]), .out_ready_i(out_ready_i));
  end

  bit            sel = 1'b0;
  logic          v_busy, v_done, v_error, v_mem_req, v_out_valid, v_out_last;
  logic [AW-1:0] v_err_addr, v_beat, v_mem_addr, v_out_addr;
  logic [1:0]    v_mem_size;
  logic [DW-1:0] v_out_data;
  assign v_busy      = d_busy[sel];
  assign v_done      = d_done[sel];
  assign v_error     = d_error[sel];
  assign v_mem_req   = d_mem_req[sel];
  assign v_out_valid = d_out_valid[sel];
  assign v_out_last  = d_out_last[sel];
  assign v_err_addr  = d_err_addr[sel];
  assign v_beat      = d_beat[sel];
  assign v_mem_addr  = d_mem_addr[sel];
  assign v_out_addr  = d_out_addr[sel];
  assign v_mem_size  = d_mem_size[sel];
  assign v_out_data  = d_out_data[sel];

  int tests = 0, failed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory: grants (optionally at random), answers one cycle later with rdata = addr.
  bit            gnt_en = 1'b1, gnt_rand = 1'b0, err_en = 1'b0, pend = 1'b0;
  logic [AW-1:0] err_at = '0, pend_addr = '0;
  int            req_cnt = 0;
  always @(posedge clk) begin
    #2;
    mem_rvalid_i = 1'b0;
    mem_rerr_i   = 1'b0;
    if (pend) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = pend_addr;
      mem_rerr_i   = err_en && (pend_addr == err_at);
      pend         = 1'b0;
    end
    mem_gnt_i = v_mem_req && gnt_en && (!gnt_rand || ($urandom_range(1, 0) == 1));
    if (mem_gnt_i) begin
      pend      = 1'b1;
      pend_addr = v_mem_addr;
      req_cnt++;
    end
  end

  logic [AW-1:0] got_addr[$];
  logic [DW-1:0] got_data[$];
  logic          got_last[$];
  int            hs_cyc[$];

  int ready_mode = 0, stall_left = 0, stall_req = 0;
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      1: out_ready_i = ($urandom_range(2, 0) != 0);
      2: begin
        if (v_out_valid && got_addr.size() == 1 && stall_left > 0) begin
          out_ready_i = 1'b0;
          stall_left--;
          if (v_mem_req) stall_req++;
        end else begin
          out_ready_i = 1'b1;
        end
      end
      default: out_ready_i = 1'b1;
    endcase
  end

  int            cyc = 0, done_cnt = 0, req_cycles = 0, hold_viol = 0, busy_viol = 0;
  bit            p_rst = 1'b1, p_stall = 1'b0, p_req = 1'b0, p_gnt = 1'b0, p_last = 1'b0;
  logic [AW-1:0] p_addr = '0, p_maddr = '0;
  logic [DW-1:0] p_data = '0;
  always @(negedge clk) begin
    cyc++;
    if (!rst_i && !p_rst) begin
      if (v_out_valid && out_ready_i) begin
        got_addr.push_back(v_out_addr);
        got_data.push_back(v_out_data);
        got_last.push_back(v_out_last);
        hs_cyc.push_back(cyc);
      end
      if (v_done) begin
        done_cnt++;
        if (v_busy) busy_viol++;
      end
      if (v_mem_req) req_cycles++;
      if (p_stall && !abort_i && (!v_out_valid || v_out_data !== p_data ||
                                  v_out_addr !== p_addr || v_out_last !== p_last)) hold_viol++;
      if (p_req && !p_gnt && !abort_i && (!v_mem_req || v_mem_addr !== p_maddr)) hold_viol++;
    end
    p_rst   = rst_i;
    p_stall = v_out_valid && !out_ready_i;
    p_data  = v_out_data;
    p_addr  = v_out_addr;
    p_last  = v_out_last;
    p_req   = v_mem_req;
    p_gnt   = mem_gnt_i;
    p_maddr = v_mem_addr;
  end

  // Reference: list of addresses a scan should deliver, straight from the rules.
  logic [AW-1:0] m_exp[$];
  bit            m_err, m_cfg_err;
  logic [AW-1:0] m_eaddr, m_end;
  logic [1:0]    m_size;
  task automatic model(input logic [AW-1:0] b, e, input logic [1:0] s, input bit ee,
                       input logic [AW-1:0] ea);
    longint stride = 64'd2 << s;
    m_exp.delete();
    m_err = 1'b0; m_cfg_err = 1'b0; m_eaddr = '0; m_end = e; m_size = s;
    if (s == 2'd3 || e < b || (b % stride) != 0 || ((e - b) % stride) != 0) begin
      m_err = 1'b1; m_cfg_err = 1'b1; m_eaddr = b;
    end else begin
      for (longint a = b; a <= e; a += stride) begin
        if (ee && a == ea) begin
          m_err = 1'b1; m_eaddr = a[AW-1:0];
          break;
        end
        m_exp.push_back(a[AW-1:0]);
      end
    end
  endtask

  bit start_busy;
  task automatic run_scan(input logic [AW-1:0] b, e, input logic [1:0] s, input bit ee,
                          input logic [AW-1:0] ea, input int budget, output bit to);
    int n = 0;
    got_addr.delete(); got_data.delete(); got_last.delete(); hs_cyc.delete();
    done_cnt = 0; req_cnt = 0; req_cycles = 0; hold_viol = 0; busy_viol = 0;
    err_en = ee; err_at = ea;
    model(b, e, s, ee, ea);
    cfg_begin_i = b; cfg_end_i = e; cfg_size_i = s; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    cfg_begin_i = $urandom; cfg_end_i = $urandom; cfg_size_i = 2'($urandom_range(3, 0));
    start_busy = v_busy;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    to = (done_cnt == 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic compare_model(input string tag, input bit to);
    int bad = 0;
    chk({tag, " timeout"}, to, 0);
    chk({tag, " beats"}, got_addr.size(), m_exp.size());
    foreach (m_exp[k]) begin
      if (k >= got_addr.size() || got_addr[k] !== m_exp[k] || got_data[k] !== m_exp[k] ||
          got_last[k] !== (m_exp[k] == m_end)) bad++;
    end
    chk({tag, " beat_seq"}, bad, 0);
    chk({tag, " error_o"}, v_error, m_err);
    if (m_err) chk({tag, " err_addr_o"}, v_err_addr, m_eaddr);
    chk({tag, " beat_count_o"}, v_beat, m_exp.size());
    chk({tag, " done_pulses"}, done_cnt, 1);
    chk({tag, " busy_end"}, {v_busy, busy_viol != 0}, 2'b00);
    chk({tag, " busy_after_start"}, start_busy, !m_cfg_err);
    chk({tag, " hold_stable"}, hold_viol, 0);
    chk({tag, " requests"}, req_cnt, m_exp.size() + ((m_err && !m_cfg_err) ? 1 : 0));
    chk({tag, " mem_size_o"}, v_mem_size, m_size);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    abort_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ctl_zero"}, {v_busy, v_done, v_error, v_mem_req, v_out_valid, v_out_last}, 0);
    chk({tag, " addr_zero"}, {v_err_addr, v_beat, v_mem_addr, v_out_addr}, 0);
    chk({tag, " data_zero"}, {v_out_data, v_mem_size}, 0);
  endtask

  typedef struct {
    logic [AW-1:0] b;
    logic [AW-1:0] e;
    logic [1:0]    s;
    bit            ee;
    logic [AW-1:0] ea;
    int            rmode;
    int            beats;
    bit            err;
    logic [AW-1:0] eaddr;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit to;
    int n;
    tbl[0] = '{32'h1000, 32'h11C0, 2'd1, 1'b0, 32'h0,    0, 113, 1'b0, 32'h0};
    tbl[1] = '{32'h1000, 32'h11C0, 2'd1, 1'b1, 32'h1010, 0, 4,   1'b1, 32'h1010};
    tbl[2] = '{32'h1002, 32'h1100, 2'd1, 1'b0, 32'h0,    0, 0,   1'b1, 32'h1002};
    tbl[3] = '{32'h1000, 32'h0FF0, 2'd1, 1'b0, 32'h0,    0, 0,   1'b1, 32'h1000};
    tbl[4] = '{32'h1000, 32'h1100, 2'd3, 1'b0, 32'h0,    0, 0,   1'b1, 32'h1000};
    tbl[5] = '{32'h0,    32'h10,   2'd2, 1'b0, 32'h0,    2, 3,   1'b0, 32'h0};

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_i = 1'b0;

    for (int i = 0; i < 6; i++) begin
      string tag = $sformatf("tbl%0d", i);
      ready_mode = tbl[i].rmode; stall_left = 5; stall_req = 0; gnt_rand = 1'b0;
      run_scan(tbl[i].b, tbl[i].e, tbl[i].s, tbl[i].ee, tbl[i].ea, tbl[i].beats * 20 + 100, to);
      compare_model(tag, to);
      chk({tag, " exp_beats"}, got_addr.size(), tbl[i].beats);
      chk({tag, " exp_error"}, v_error, tbl[i].err);
      if (tbl[i].err) chk({tag, " exp_err_addr"}, v_err_addr, tbl[i].eaddr);
      if (tbl[i].beats == 0) chk({tag, " no_request"}, req_cycles, 0);
      if (i == 0) begin
        int bad = 0;
        for (int k = 1; k < hs_cyc.size(); k++) if (hs_cyc[k] - hs_cyc[k-1] != 11) bad++;
        chk({tag, " beat_period"}, bad, 0);
      end
      if (i == 5) chk({tag, " stall_no_req"}, {stall_left, stall_req}, 0);
    end
    ready_mode = 0;

    // Abort while the second response is outstanding.
    got_addr.delete(); got_data.delete(); got_last.delete();
    done_cnt = 0; req_cnt = 0; err_en = 1'b0;
    cfg_begin_i = 32'h0; cfg_end_i = 32'h40; cfg_size_i = 2'd1; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    n = 0;
    while (got_addr.size() < 1 && n < 100) begin @(posedge clk); #1; n++; end
    while (!v_mem_req && n < 200) begin @(posedge clk); #1; n++; end
    chk("abort reach_req", n < 200, 1);
    @(posedge clk); #1;
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("abort beats", got_addr.size(), 1);
    chk("abort done_pulses", done_cnt, 1);
    chk("abort beat_count_o", v_beat, 1);
    chk("abort error_o", v_error, 0);
    chk("abort requests", req_cnt, 2);
    chk("abort busy_o", v_busy, 0);

    // Reset while a request waits for a grant; the late response must be ignored.
    do_reset();
    sel = 1'b1;
    gnt_en = 1'b0;
    cfg_begin_i = 32'h100; cfg_end_i = 32'h200; cfg_size_i = 2'd1; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    n = 0;
    while (!v_mem_req && n < 20) begin @(posedge clk); #1; n++; end
    chk("rst reach_req", v_mem_req, 1);
    @(posedge clk); #1;
    rst_i = 1'b1; gnt_en = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk_zero("rst mid_scan");
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst late_resp");
    run_scan(32'h20, 32'h20, 2'd0, 1'b0, 32'h0, 50, to);
    compare_model("rst rescan", to);
    chk("rst rescan_last", (got_last.size() == 1) ? {got_addr[0], got_last[0]} : 33'h0, {32'h20, 1'b1});

    // Random scans, including config errors, read errors, backpressure and grant delays.
    ready_mode = 1; gnt_rand = 1'b1;
    for (int i = 0; i < 24; i++) begin
      logic [AW-1:0] b, e, ea;
      logic [1:0] s;
      int stride, cnt, kind;
      bit ee;
      if (sel != i[0]) begin
        sel = i[0];
        do_reset();
      end
      s = 2'($urandom_range(2, 0));
      stride = 2 << s;
      cnt = $urandom_range(6, 1);
      b = 32'($urandom_range(255, 0) * stride);
      e = b + 32'((cnt - 1) * stride);
      kind = $urandom_range(9, 0);
      case (kind)
        0: s = 2'd3;
        1: begin b = b + 32'h400; e = b - 32'(stride); end
        2: begin b = b + 32'h1; e = e + 32'h1; end
        3: e = e + 32'h1;
        default: ;
      endcase
      ee = ($urandom_range(2, 0) == 0);
      ea = b + 32'($urandom_range(cnt - 1, 0) * stride);
      run_scan(b, e, s, ee, ea, 60 * (cnt + 1) + 50, to);
      compare_model($sformatf("rnd%0d", i), to);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_scan_ctrl.md
# mem_scan_ctrl

Sequencer that walks a configured inclusive address range on the Renode memory read path, issuing one single-beat read at a time and forwarding each returned word to a downstream consumer. It sits between a configuration/test controller and the memory-side request port. It provides the begin/end/stride scan, inter-request spacing and stop-on-error behaviour in hardware, so dump and checker logic only consume a valid/ready stream.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, read data width
- GAP_CYCLES, 8, idle cycles inserted before every request (0 allowed)
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous and active-high
- start_i  in  1  start a scan; sampled only in IDLE
- abort_i  in  1  stop the scan at the next safe point
- cfg_begin_i  in  ADDR_W  first address; sampled on accepted start
- cfg_end_i  in  ADDR_W  last address, inclusive; sampled on accepted start
- cfg_size_i  in  2  access size: 0 = Word (2 B), 1 = DoubleWord (4 B), 2 = QuadWord (8 B), 3 = illegal
- busy_o  out  1  scan in progress
- done_o  out  1  one-cycle pulse when the scan ends (normal, abort or error)
- error_o  out  1  sticky error flag; cleared on the next accepted start
- err_addr_o  out  ADDR_W  address of the failing access, or cfg_begin for a config error
- beat_count_o  out  ADDR_W  beats delivered downstream in the current or last scan
- mem_req_o  out  1  read request
- mem_addr_o  out  ADDR_W  request address
- mem_size_o  out  2  equals the latched cfg_size
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  response valid
- mem_rdata_i  in  DATA_W  response data
- mem_rerr_i  in  1  response error, qualified by mem_rvalid_i
- out_valid_o  out  1  output beat valid
- out_data_o  out  DATA_W  read data
- out_addr_o  out  ADDR_W  address of the beat
- out_last_o  out  1  beat at cfg_end

## Operation
- States: IDLE, GAP, REQ, WAIT, PUSH.
- IDLE + start_i:
  - Latch the config, clear error_o and beat_count_o, set addr = cfg_begin.
  - Config check: size 3, cfg_end < cfg_begin, cfg_begin not aligned to the stride, or (cfg_end − cfg_begin) not a multiple of the stride.
  - On a config error: error_o = 1, err_addr_o = cfg_begin, done_o pulses next cycle, stay in IDLE, issue no request.
  - Otherwise go to GAP.
- GAP: count GAP_CYCLES cycles, then go to REQ. When GAP_CYCLES = 0, go directly to REQ.
- REQ: mem_req_o = 1 with a stable address. Go to WAIT on the cycle mem_gnt_i = 1. Only one request is outstanding at a time.
- WAIT: on mem_rvalid_i:
  - If mem_rerr_i = 1: error_o = 1, err_addr_o = addr, done_o pulses, go to IDLE, emit no beat.
  - Else register the data and go to PUSH.
- PUSH: out_valid_o = 1 and is held, with data stable, until out_ready_i.
- On handshake:
  - beat_count_o is incremented.
  - If addr == cfg_end: done_o pulses and the block goes to IDLE.
  - Else addr += stride (2/4/8) and the block goes to GAP.
- Arithmetic: the compare uses equality on the latched end, never ≥. Address increment is modulo 2^ADDR_W. The config check guarantees cfg_end is hit before any wrap.
- Abort (level, sampled each cycle):
  - In GAP, REQ before grant, or PUSH before handshake: done_o pulses and the block goes to IDLE. A pending beat is dropped; error_o is unchanged.
  - In WAIT: the response is still awaited and then discarded, with no PUSH. The block then ends as above.
  - Abort in REQ on the same cycle as mem_gnt_i: the grant wins, and the abort is handled in WAIT.
- start_i outside IDLE is ignored.

## Timing
- Reset values:
  - State IDLE.
  - busy_o, done_o, error_o, mem_req_o, out_valid_o, out_last_o = 0.
  - All address, data and count outputs = 0.
- Reset mid-scan returns to IDLE on the next edge. An in-flight response arriving afterwards is ignored.
- busy_o = 1 in every state except IDLE. It goes high the cycle after an accepted start and low in the same cycle done_o is high.
- All outputs are registered. There is no combinational path from any input to any output.
- Per-beat latency:
  - Normal beat: GAP_CYCLES + 1 (REQ, grant the same cycle) + response latency + 1 (PUSH, ready high).
  - With GAP_CYCLES = 8 and a 1-cycle response latency: 11 cycles per beat.
- mem_req_o and mem_addr_o stay stable until the grant. out_* stay stable while out_valid_o && !out_ready_i.
- mem_rvalid_i is ignored outside WAIT.

## Test plan
- Begin 0x1000, end 0x11C0, size DoubleWord, mem always grants with 1-cycle latency, rdata = addr, ready always high -> 113 beats at addresses 0x1000..0x11C0 step 4, out_last_o only on 0x11C0, one done_o pulse, beat_count_o = 113, error_o = 0.
- Same scan with mem_rerr_i on the response for 0x1010 -> beats 0x1000..0x100C only, error_o = 1, err_addr_o = 0x1010, done_o pulses, no request issued after.
- Config errors: begin 0x1002 with size DoubleWord; end 0x0FF0 < begin 0x1000; size 3 -> each gives error_o = 1, no mem_req_o, done_o pulses.
- Backpressure: out_ready_i low for 5 cycles on the second beat, size QuadWord, range 0x0..0x10 -> data held stable, 3 beats at 0x0/0x8/0x10, no request issued while stalled.
- Abort asserted in WAIT during beat 2 of 0x0..0x40 step 4 -> response consumed, no beat 2 output, done_o pulses, beat_count_o = 1.
- rst_i pulsed during REQ, then a fresh start of 0x20..0x20 size Word with GAP_CYCLES = 0 -> all outputs zero after reset; exactly one beat at 0x20 with out_last_o = 1.
